// File: rtl/i2c_master_byte.sv
// Single-master I2C byte initiator: START, address+R/W, one data byte, STOP on
// open-drain SCL/SDA, with ACK checking and slave clock-stretch support.
module i2c_master_byte #(
  parameter int CLK_DIV        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                      clk_i2c,
  input  logic                      rst_i2c,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [I2C_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                      cmd_rw,
  input  logic [I2C_DATA_WIDTH-1:0] cmd_wdata,
  output logic [I2C_DATA_WIDTH-1:0] rdata,
  output logic                      done,
  output logic                      nack_err,
  output logic                      busy,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe,
  output logic                      sda_oe
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW   = I2C_ADDR_WIDTH + 1;
  localparam int DATW = I2C_DATA_WIDTH;
  localparam int BW   = $clog2((AW > DATW) ? AW : DATW) + 1;
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_ONE   = DIVW'(1);
  localparam logic [BW-1:0]   ADDR_LAST = BW'(AW - 1);
  localparam logic [BW-1:0]   DATA_LAST = BW'(DATW - 1);
  localparam logic [BW-1:0]   BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  logic            rst_meta_r, rst_sync_r;
  logic            scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
  state_t          state_r, nxt_state_s;
  logic [DIVW-1:0] div_r, nxt_div_s;
  logic [1:0]      qtr_r, nxt_qtr_s;
  logic [BW-1:0]   bit_r, nxt_bit_s;
  logic [AW-1:0]   addr_sh_r, nxt_addr_sh_s;
  logic [DATW-1:0] data_sh_r, nxt_data_sh_s;
  logic [DATW-1:0] rdata_r, nxt_rdata_s;
  logic            rw_r, nxt_rw_s;
  logic            ready_r, nxt_ready_s;
  logic            busy_r, nxt_busy_s;
  logic            nack_r, nxt_nack_s;
  logic            done_r, nxt_done_s;
  logic            scl_oe_r, nxt_scl_oe_s;
  logic            sda_oe_r, nxt_sda_oe_s;
  logic            q_end_s, bit_phase_s, stretch_s;

  // Reset synchronizer: asserts immediately, releases on clk_i2c.
  always_ff @(posedge clk_i2c or negedge rst_i2c) begin
    if (!rst_i2c) begin
      {rst_meta_r, rst_sync_r} <= 2'b00;
    end else begin
      {rst_meta_r, rst_sync_r} <= {1'b1, rst_meta_r};
    end
  end

  // Two-flop synchronizers for the bus lines; idle bus reads high.
  always_ff @(posedge clk_i2c or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      {scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r} <= 4'b1111;
    end else begin
      {scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r} <= {scl_i, scl_meta_r, sda_i, sda_meta_r};
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i2c or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r   <= ST_IDLE;
      div_r     <= {DIVW{1'b0}};
      qtr_r     <= 2'd0;
      bit_r     <= {BW{1'b0}};
      addr_sh_r <= {AW{1'b0}};
      data_sh_r <= {DATW{1'b0}};
      rdata_r   <= {DATW{1'b0}};
      rw_r      <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      nack_r    <= 1'b0;
      done_r    <= 1'b0;
      scl_oe_r  <= 1'b0;
      sda_oe_r  <= 1'b0;
    end else begin
      state_r   <= nxt_state_s;
      div_r     <= nxt_div_s;
      qtr_r     <= nxt_qtr_s;
      bit_r     <= nxt_bit_s;
      addr_sh_r <= nxt_addr_sh_s;
      data_sh_r <= nxt_data_sh_s;
      rdata_r   <= nxt_rdata_s;
      rw_r      <= nxt_rw_s;
      ready_r   <= nxt_ready_s;
      busy_r    <= nxt_busy_s;
      nack_r    <= nxt_nack_s;
      done_r    <= nxt_done_s;
      scl_oe_r  <= nxt_scl_oe_s;
      sda_oe_r  <= nxt_sda_oe_s;
    end
  end

  // Next-state, quarter timing and line drive (derived from next state so lines track quarters exactly).
  always_comb begin
    nxt_state_s   = state_r;
    nxt_div_s     = div_r;
    nxt_qtr_s     = qtr_r;
    nxt_bit_s     = bit_r;
    nxt_addr_sh_s = addr_sh_r;
    nxt_data_sh_s = data_sh_r;
    nxt_rdata_s   = rdata_r;
    nxt_rw_s      = rw_r;
    nxt_ready_s   = ready_r;
    nxt_busy_s    = busy_r;
    nxt_nack_s    = nack_r;
    nxt_done_s    = 1'b0;
    nxt_scl_oe_s  = 1'b0;
    nxt_sda_oe_s  = 1'b0;
    q_end_s       = (div_r == DIV_LAST);
    bit_phase_s   = (state_r == ST_ADDR) || (state_r == ST_ADDR_ACK) ||
                    (state_r == ST_DATA) || (state_r == ST_DATA_ACK);
    // A slave holding SCL low freezes the divider on the last clock of the high phase.
    stretch_s     = q_end_s && !scl_sync_r &&
                    ((bit_phase_s && (qtr_r == 2'd2)) || ((state_r == ST_STOP) && (qtr_r == 2'd1)));

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          nxt_state_s   = ST_START;
          nxt_div_s     = {DIVW{1'b0}};
          nxt_qtr_s     = 2'd0;
          nxt_bit_s     = {BW{1'b0}};
          nxt_addr_sh_s = {cmd_addr, cmd_rw};
          nxt_data_sh_s = cmd_wdata;
          nxt_rw_s      = cmd_rw;
          nxt_ready_s   = 1'b0;
          nxt_busy_s    = 1'b1;
          nxt_nack_s    = 1'b0;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        nxt_done_s  = 1'b1;
        nxt_ready_s = 1'b1;
        nxt_busy_s  = 1'b0;
        nxt_state_s = ST_IDLE;
      end
      default: begin
        if (!q_end_s) begin
          nxt_div_s = div_r + DIV_ONE;
        end else if (stretch_s) begin
          nxt_div_s = div_r;
        end else begin
          nxt_div_s = {DIVW{1'b0}};
          nxt_qtr_s = qtr_r + 2'd1;
          case (state_r)
            ST_START: begin
              if (qtr_r == 2'd1) begin
                nxt_state_s = ST_ADDR;
                nxt_qtr_s   = 2'd0;
                nxt_bit_s   = {BW{1'b0}};
              end else begin
                nxt_state_s = ST_START;
              end
            end
            ST_ADDR: begin
              if (qtr_r == 2'd3) begin
                nxt_addr_sh_s = {addr_sh_r[AW-2:0], 1'b0};
                if (bit_r == ADDR_LAST) begin
                  nxt_state_s = ST_ADDR_ACK;
                end else begin
                  nxt_bit_s = bit_r + BIT_ONE;
                end
              end else begin
                nxt_state_s = ST_ADDR;
              end
            end
            ST_ADDR_ACK: begin
              if (qtr_r == 2'd3) begin
                if (sda_sync_r) begin
                  nxt_nack_s  = 1'b1;
                  nxt_state_s = ST_STOP;
                end else begin
                  nxt_state_s = ST_DATA;
                  nxt_bit_s   = {BW{1'b0}};
                end
              end else begin
                nxt_state_s = ST_ADDR_ACK;
              end
            end
            ST_DATA: begin
              if (qtr_r == 2'd3) begin
                nxt_data_sh_s = {data_sh_r[DATW-2:0], sda_sync_r};
                if (bit_r == DATA_LAST) begin
                  nxt_state_s = ST_DATA_ACK;
                  nxt_rdata_s = rw_r ? {data_sh_r[DATW-2:0], sda_sync_r} : rdata_r;
                end else begin
                  nxt_bit_s = bit_r + BIT_ONE;
                end
              end else begin
                nxt_state_s = ST_DATA;
              end
            end
            ST_DATA_ACK: begin
              if (qtr_r == 2'd3) begin
                nxt_nack_s  = nack_r | (!rw_r && sda_sync_r);
                nxt_state_s = ST_STOP;
              end else begin
                nxt_state_s = ST_DATA_ACK;
              end
            end
            ST_STOP: begin
              if (qtr_r == 2'd3) begin
                nxt_state_s = ST_DONE;
              end else begin
                nxt_state_s = ST_STOP;
              end
            end
            default: nxt_state_s = state_r;
          endcase
        end
      end
    endcase

    case (nxt_state_s)
      ST_START: nxt_sda_oe_s = (nxt_qtr_s == 2'd1);
      ST_ADDR: begin
        nxt_scl_oe_s = !nxt_qtr_s[1];
        nxt_sda_oe_s = !nxt_addr_sh_s[AW-1];
      end
      ST_DATA: begin
        nxt_scl_oe_s = !nxt_qtr_s[1];
        nxt_sda_oe_s = !nxt_rw_s && !nxt_data_sh_s[DATW-1];
      end
      ST_ADDR_ACK, ST_DATA_ACK: nxt_scl_oe_s = !nxt_qtr_s[1];
      ST_STOP: begin
        nxt_scl_oe_s = (nxt_qtr_s == 2'd0);
        nxt_sda_oe_s = !nxt_qtr_s[1];
      end
      default: begin
        nxt_scl_oe_s = 1'b0;
        nxt_sda_oe_s = 1'b0;
      end
    endcase
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign nack_err  = nack_r;
  assign rdata     = rdata_r;
  assign scl_oe    = scl_oe_r;
  assign sda_oe    = sda_oe_r;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte: open-drain bus with a small reactive
// slave, latency, bus-content, NACK, stretch, back-pressure and reset checks.
module tb_i2c_master_byte;

  logic       clk_i2c = 1'b0;
  logic       rst_i2c = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'd0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'd0;
  logic [7:0] rdata;
  logic       done, nack_err, busy;
  logic       scl_i, sda_i, scl_oe, sda_oe;

  // slave model state
  logic        slv_sda_low = 1'b0;
  logic        slv_scl_hold = 1'b0;
  logic [6:0]  slv_addr = 7'h50;
  logic        slv_ack_data = 1'b1;
  logic [7:0]  slv_rd = 8'h00;
  logic        slv_acked = 1'b0;
  logic        slv_rw = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [31:0] bus_log = 32'd0;
  int          rises = 0;
  int          stops = 0;
  int          done_cnt = 0;

  int checks = 0;
  int errors = 0;
  int nn = 0;
  int stops0 = 0;
  int dc0 = 0;

  always #5 clk_i2c = ~clk_i2c;

  assign scl_i = !(scl_oe || slv_scl_hold);
  assign sda_i = !(sda_oe || slv_sda_low);

  i2c_master_byte #(.CLK_DIV(4), .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8)) dut (
    .clk_i2c(clk_i2c), .rst_i2c(rst_i2c),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .rdata(rdata), .done(done),
    .nack_err(nack_err), .busy(busy), .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  // Reactive slave: logs every SDA value seen on a rising SCL, drives ACK/read data after falling SCL.
  always @(negedge clk_i2c) begin
    if (prev_scl && scl_i && prev_sda && !sda_i) begin
      rises = 0; bus_log = 32'd0; slv_sda_low = 1'b0; slv_acked = 1'b0;
    end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
      stops = stops + 1;
    end else if (!prev_scl && scl_i) begin
      bus_log = {bus_log[30:0], sda_i};
      rises = rises + 1;
    end else if (prev_scl && !scl_i) begin
      slv_sda_low = 1'b0;
      if (rises == 8) begin
        slv_rw      = bus_log[0];
        slv_acked   = (bus_log[7:1] == slv_addr);
        slv_sda_low = slv_acked;
      end else if (slv_acked && slv_rw && rises >= 9 && rises <= 16) begin
        slv_sda_low = !slv_rd[16-rises];
      end else if (slv_acked && !slv_rw && rises == 17) begin
        slv_sda_low = slv_ack_data;
      end
    end
    prev_scl = scl_i;
    prev_sda = sda_i;
  end

  always @(negedge clk_i2c) if (done === 1'b1) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i2c);
    nn++;
    #1;
  endtask

  // Called #1 after a clock edge while idle; returns #1 after the acceptance edge (nn = 0).
  task automatic start_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd);
    cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
    stops0 = stops;
    @(posedge clk_i2c);
    nn = 0;
    #1;
    cmd_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_ready", 32'(cmd_ready), 32'd0);
    chk("accept_nack_clr", 32'(nack_err), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    while (done !== 1'b1 && nn < 3000) tick();
    chk({tag, "_done_edge"}, 32'(nn), 32'(exp_n));
    chk({tag, "_stop_seen"}, 32'(stops - stops0), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'({done, cmd_ready, busy}), 32'b010);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk_i2c);
    #1;
    chk("rst_hold_flags", 32'({cmd_ready, busy, done, nack_err, scl_oe, sda_oe}), 32'b100000);
    rst_i2c = 1'b1;
    repeat (5) tick();
    chk("rst_flags", 32'({cmd_ready, busy, done, nack_err, scl_oe, sda_oe}), 32'b100000);
    chk("rst_rdata", 32'(rdata), 32'h00);

    // write 0x50 <- 0xA5, both ACKed
    start_cmd(7'h50, 1'b0, 8'hA5);
    wait_done("wr", 313);
    chk("wr_nack", 32'(nack_err), 32'd0);
    chk("wr_rises", 32'(rises), 32'd19);
    chk("wr_bus", bus_log, 32'({8'hA0, 1'b0, 8'hA5, 1'b0, 1'b0}));
    chk("wr_rdata", 32'(rdata), 32'h00);

    // read 0x3C -> 0x5A, master NACKs the byte
    slv_addr = 7'h3C; slv_rd = 8'h5A;
    start_cmd(7'h3C, 1'b1, 8'h00);
    wait_done("rd", 313);
    chk("rd_rdata", 32'(rdata), 32'h5A);
    chk("rd_nack", 32'(nack_err), 32'd0);
    chk("rd_bus", bus_log, 32'({8'h79, 1'b0, 8'h5A, 1'b1, 1'b0}));

    // address NACK
    slv_addr = 7'h50;
    start_cmd(7'h11, 1'b0, 8'h33);
    wait_done("anack", 169);
    chk("anack_nack", 32'(nack_err), 32'd1);
    chk("anack_rises", 32'(rises), 32'd10);
    chk("anack_bus", bus_log, 32'({8'h22, 1'b1, 1'b0}));

    // write data NACK
    slv_ack_data = 1'b0;
    start_cmd(7'h50, 1'b0, 8'hFF);
    wait_done("dnack", 313);
    chk("dnack_nack", 32'(nack_err), 32'd1);
    chk("dnack_rdata", 32'(rdata), 32'h5A);
    chk("dnack_bus", bus_log, 32'({8'hA0, 1'b0, 8'hFF, 1'b1, 1'b0}));

    // 20-clock stretch on the fourth address bit
    slv_ack_data = 1'b1;
    start_cmd(7'h50, 1'b0, 8'hA5);
    while (nn < 58) tick();
    slv_scl_hold = 1'b1;
    while (nn < 85) tick();
    chk("str_held_scl", 32'(scl_oe), 32'd0);
    slv_scl_hold = 1'b0;
    wait_done("str", 333);
    chk("str_nack", 32'(nack_err), 32'd0);
    chk("str_bus", bus_log, 32'({8'hA0, 1'b0, 8'hA5, 1'b0, 1'b0}));

    // cmd_valid while busy is ignored
    dc0 = done_cnt;
    start_cmd(7'h50, 1'b0, 8'h3C);
    while (nn < 50) tick();
    cmd_addr = 7'h7F; cmd_wdata = 8'h00; cmd_valid = 1'b1;
    while (nn < 60) tick();
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_done("bp", 313);
    chk("bp_bus", bus_log, 32'({8'hA0, 1'b0, 8'h3C, 1'b0, 1'b0}));
    repeat (400) tick();
    chk("bp_one_done", 32'(done_cnt - dc0), 32'd1);
    chk("bp_idle", 32'({busy, cmd_ready}), 32'b01);

    // reset during data bit 4
    start_cmd(7'h50, 1'b0, 8'hA5);
    while (nn < 217) tick();
    chk("mrst_pre_lines", 32'({scl_oe, sda_oe}), 32'b11);
    rst_i2c = 1'b0;
    #1;
    chk("mrst_lines", 32'({scl_oe, sda_oe}), 32'b00);
    chk("mrst_flags", 32'({cmd_ready, busy}), 32'b10);
    repeat (3) tick();
    rst_i2c = 1'b1;
    repeat (4) tick();
    chk("mrst_after", 32'({cmd_ready, busy, done, nack_err, scl_oe, sda_oe}), 32'b100000);

    // recovery transfer
    start_cmd(7'h50, 1'b0, 8'h0F);
    wait_done("rec", 313);
    chk("rec_bus", bus_log, 32'({8'hA0, 1'b0, 8'h0F, 1'b0, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Synthesizable single-master I2C initiator for the Wishbone/I2C verification environment; the driving end of the bus that the slave-side I2C interface monitors and responds to.
- Accepts one command (7-bit address, R/W, one data byte) over a valid/ready handshake.
- Generates START, address+R/W, one data byte and STOP on open-drain SCL/SDA, checking the slave's ACKs.
- Supports slave clock stretching.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period. Legal values are 4 or greater.
- I2C_ADDR_WIDTH, 7: slave address width.
- I2C_DATA_WIDTH, 8: data byte width.

Ports:
- clk_i2c  input  1  system clock
- rst_i2c  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block idle and able to accept a command
- cmd_addr  input  I2C_ADDR_WIDTH  target slave address
- cmd_rw  input  1  0 = WRITE, 1 = READ
- cmd_wdata  input  I2C_DATA_WIDTH  write byte
- rdata  output  I2C_DATA_WIDTH  byte read from slave
- done  output  1  one-cycle pulse at end of transfer
- nack_err  output  1  slave NACKed address or write data (valid with done)
- busy  output  1  transfer in progress
- scl_i  input  1  SCL line level
- sda_i  input  1  SDA line level
- scl_oe  output  1  1 = pull SCL low, 0 = release
- sda_oe  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset (async assert, sync deassert to clk_i2c) drives outputs to: cmd_ready=1, busy=0, done=0, nack_err=0, rdata=0, scl_oe=0, sda_oe=0, state=IDLE, all counters cleared.
- Reset mid-transfer releases both lines immediately. No STOP is generated.
- scl_i and sda_i pass through 2-FF synchronizers. Internal logic uses only the synchronized copies.
- Handshake: command accepted on a clock edge where cmd_valid && cmd_ready. Inputs are latched on that edge, and cmd_ready drops to 0 with busy going to 1.
- cmd_ready returns to 1 on the same edge that asserts done.
- cmd_valid while busy is ignored.
- Timing unit is the quarter q. Each quarter lasts CLK_DIV clocks, counted by a divider counter.
- START state (2 quarters):
  - q0: both lines released.
  - q1: sda_oe=1, scl released.
- ADDR state: 8 bits, address MSB first, then R/W.
- Every bit (4 quarters):
  - q0: scl_oe=1, SDA set to the bit value (sda_oe = ~bit).
  - q1: scl_oe=1.
  - q2: scl released.
  - q3: scl released.
- Clock stretching: in the final clock of q2, if synchronized SCL is 0, the divider holds until it reads 1.
- Receive sampling: synchronized SDA is sampled in the final clock of q3.
- ADDR_ACK state: one bit with SDA released.
  - Sampled 0 -> go to DATA.
  - Sampled 1 -> nack_err=1, skip to STOP.
- DATA state, WRITE: 8 bits of cmd_wdata, MSB first. Then DATA_ACK with SDA released; sampled 1 sets nack_err=1.
- DATA state, READ: SDA released for 8 bits, shifted MSB-first into a shift register. rdata updates at the end of bit 0.
  - The master then sends NACK (SDA released) in DATA_ACK, terminating the read.
- STOP state (4 quarters):
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl released, sda_oe=1; stretch hold applies at the end of q1.
  - q2: both released.
  - q3: both released.
  - Then DONE.
- DONE: done=1 for exactly one clock, then IDLE.
- nack_err holds until the next accepted command, which clears it.
- Latency without stretching: 78 quarters (2 + 36 + 36 + 4). done rises on edge E + 78*CLK_DIV + 1, where E is the acceptance edge.
- Address NACK: 42 quarters (2 + 36 + 4).
- Single master only: no arbitration-loss detection, no repeated START.
- sda_oe changes only while SCL is driven low, except in START q1 and STOP q2.

Test Plan:
- Write: reset, CLK_DIV=4, command addr=0x50, rw=0, wdata=0xA5, slave ACKs both bytes.
  - Bus shows START, bits 1010000 0, ACK, 10100101, ACK, STOP.
  - done at E+313, nack_err=0.
- Read: addr=0x3C, rw=1, slave drives 0x5A.
  - rdata=0x5A, master leaves SDA released on the 9th data bit (NACK), STOP.
  - done at E+313.
- Address NACK: addr=0x11, no slave response.
  - STOP directly after the address ACK bit, nack_err=1, done at E+169.
- Write data NACK: slave ACKs address and NACKs data 0xFF.
  - nack_err=1, STOP issued, rdata unchanged.
- Clock stretching: slave holds SCL low 20 extra clocks on address bit 3.
  - Bit timing resumes after release, done delayed by exactly 20 clocks, data intact.
- Reset and back-pressure:
  - Assert rst_i2c low during DATA bit 4 -> scl_oe=sda_oe=0 immediately, cmd_ready=1 after release.
  - cmd_valid pulsed while busy -> ignored, only one transfer occurs.
